mic_register_file_hs: RTL and testbench

//  Parametrised Mic-1 datapath register file, successor of the fixed 9-register bank.

---
 rtl/mic_register_file_hs.sv | 216 +++++++++++++++++++++
 tb/tb_mic_register_file_hs.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mic_register_file_hs.sv
// mic_register_file_hs
//   Mic-1 datapath register file. It has two combinational read ports (A and B), one
//   masked write port from the C bus, and two independent req/ack memory ports: word
//   data and byte instruction fetch. While either memory transaction is outstanding,
//   stall is asserted so that the control store holds.
//
// Parameters
//   NBITS  datapath width (>=16)
//   NREGS  writable registers H..MAR plus extra GPRs R9.. (9..16)
//   SELW   width of the A/B select codes
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-low reset
//   c_bus, write_c             write data and per-register write mask
//                              (0 H,1 OPC,2 TOS,3 CPP,4 LV,5 SP,6 PC,7 MDR,8 MAR,9+ Rn)
//   enable_a/_b, a_bus/b_bus   read selects and read data
//   mem_control                bit0 fetch, bit1 rd, bit2 wr
//   stall, mem_err             transaction outstanding, sticky protocol error
//   dmem_*                     data port (word address {MAR,2'b00})
//   imem_*                     byte fetch port (address = PC)
//
// Build option
//   PC_AUTOINC_EN: when defined, a fetch completion increments PC. A C-bus write of PC
//   in the same cycle takes priority over the increment.

module mic_register_file_hs #(
  parameter int NBITS = 32,
  parameter int NREGS = 9,
  parameter int SELW  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NBITS-1:0] c_bus,
  input  logic [NREGS-1:0] write_c,
  input  logic [SELW-1:0]  enable_a,
  input  logic [SELW-1:0]  enable_b,
  output logic [NBITS-1:0] a_bus,
  output logic [NBITS-1:0] b_bus,
  input  logic [2:0]       mem_control,
  output logic             stall,
  output logic             mem_err,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [NBITS-1:0] dmem_addr,
  output logic [NBITS-1:0] dmem_wdata,
  input  logic [NBITS-1:0] dmem_rdata,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic [NBITS-1:0] imem_addr,
  input  logic [7:0]       imem_rdata,
  input  logic             imem_ack
);

  localparam int unsigned IDX_H   = 0;
  localparam int unsigned IDX_OPC = 1;
  localparam int unsigned IDX_TOS = 2;
  localparam int unsigned IDX_CPP = 3;
  localparam int unsigned IDX_LV  = 4;
  localparam int unsigned IDX_SP  = 5;
  localparam int unsigned IDX_PC  = 6;
  localparam int unsigned IDX_MDR = 7;
  localparam int unsigned IDX_MAR = 8;

  typedef enum logic [1:0] {D_IDLE, D_RD, D_WR} dstate_e;
  typedef enum logic       {F_IDLE, F_WAIT}     fstate_e;

  logic [NBITS-1:0] regs_q [NREGS];
  logic [NBITS-1:0] regs_d [NREGS];
  logic [7:0]       mbr_q, mbr_d;
  dstate_e          dstate_q, dstate_d;
  fstate_e          fstate_q, fstate_d;
  logic             err_q, err_d;
  logic             dreq_q, dreq_d;
  logic             dwe_q, dwe_d;
  logic [NBITS-1:0] daddr_q, daddr_d;
  logic [NBITS-1:0] dwdata_q, dwdata_d;
  logic             ireq_q, ireq_d;
  logic [NBITS-1:0] iaddr_q, iaddr_d;

  logic fetch, rd, wr;
  assign fetch = mem_control[0];
  assign rd    = mem_control[1];
  assign wr    = mem_control[2];

  // Read-code decode shared by both buses; unmapped codes read as zero.
  function automatic logic [NBITS-1:0] read_sel(input logic [SELW-1:0] code);
    logic [NBITS-1:0] v;
    int unsigned      c;
    v = '0;
    c = {{(32-SELW){1'b0}}, code};
    case (c)
      0: v = regs_q[IDX_MDR];
      1: v = regs_q[IDX_PC];
      2: v = {{(NBITS-8){1'b0}}, mbr_q};
      3: v = {{(NBITS-8){mbr_q[7]}}, mbr_q};
      4: v = regs_q[IDX_SP];
      5: v = regs_q[IDX_LV];
      6: v = regs_q[IDX_CPP];
      7: v = regs_q[IDX_TOS];
      8: v = regs_q[IDX_OPC];
      9: v = regs_q[IDX_H];
      default: begin
        // Code 10+k selects extra register index 9+k.
        for (int unsigned k = 9; k < NREGS; k++) begin
          if (c == k + 1) v = regs_q[k];
        end
      end
    endcase
    return v;
  endfunction

  assign a_bus      = read_sel(enable_a);
  assign b_bus      = read_sel(enable_b);
  assign stall      = (dstate_q != D_IDLE) | (fstate_q != F_IDLE);
  assign mem_err    = err_q;
  assign dmem_req   = dreq_q;
  assign dmem_we    = dwe_q;
  assign dmem_addr  = daddr_q;
  assign dmem_wdata = dwdata_q;
  assign imem_req   = ireq_q;
  assign imem_addr  = iaddr_q;

  always_comb begin
    for (int unsigned i = 0; i < NREGS; i++) begin
      regs_d[i] = write_c[i] ? c_bus : regs_q[i];
    end
    mbr_d    = mbr_q;
    dstate_d = dstate_q;
    fstate_d = fstate_q;
    err_d    = err_q;
    dreq_d   = dreq_q;
    dwe_d    = dwe_q;
    daddr_d  = daddr_q;
    dwdata_d = dwdata_q;
    ireq_d   = ireq_q;
    iaddr_d  = iaddr_q;

    // Data port
    case (dstate_q)
      D_IDLE: begin
        if (rd & wr) begin
          err_d = 1'b1;
        end else if (rd | wr) begin
          dstate_d = rd ? D_RD : D_WR;
          dreq_d   = 1'b1;
          dwe_d    = wr;
          daddr_d  = {regs_q[IDX_MAR][NBITS-3:0], 2'b00};
          dwdata_d = regs_q[IDX_MDR];
        end
      end
      default: begin
        if (rd | wr) err_d = 1'b1;
        if (dmem_ack) begin
          // Read data takes priority over a C-bus write of MDR in the same cycle.
          if (dstate_q == D_RD) regs_d[IDX_MDR] = dmem_rdata;
          dstate_d = D_IDLE;
          dreq_d   = 1'b0;
          dwe_d    = 1'b0;
        end
      end
    endcase

    // Fetch port
    case (fstate_q)
      F_IDLE: begin
        if (fetch) begin
          fstate_d = F_WAIT;
          ireq_d   = 1'b1;
          iaddr_d  = regs_q[IDX_PC];
        end
      end
      default: begin
        if (fetch) err_d = 1'b1;
        if (imem_ack) begin
          mbr_d    = imem_rdata;
          fstate_d = F_IDLE;
          ireq_d   = 1'b0;
`ifdef PC_AUTOINC_EN
          if (!write_c[IDX_PC]) begin
            regs_d[IDX_PC] = regs_q[IDX_PC] + {{(NBITS-1){1'b0}}, 1'b1};
          end
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
      mbr_q    <= '0;
      dstate_q <= D_IDLE;
      fstate_q <= F_IDLE;
      err_q    <= 1'b0;
      dreq_q   <= 1'b0;
      dwe_q    <= 1'b0;
      daddr_q  <= '0;
      dwdata_q <= '0;
      ireq_q   <= 1'b0;
      iaddr_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
      mbr_q    <= mbr_d;
      dstate_q <= dstate_d;
      fstate_q <= fstate_d;
      err_q    <= err_d;
      dreq_q   <= dreq_d;
      dwe_q    <= dwe_d;
      daddr_q  <= daddr_d;
      dwdata_q <= dwdata_d;
      ireq_q   <= ireq_d;
      iaddr_q  <= iaddr_d;
    end
  end

endmodule

// File: tb/tb_mic_register_file_hs.sv
// Testbench for mic_register_file_hs (default parameters). Expected bus values are
// pushed to a scoreboard queue when stimulus is driven and popped when the DUT output
// is sampled. Inputs are driven on the falling edge and sampled 1 time unit later.
module tb_mic_register_file_hs;
  localparam int NBITS = 32;
  localparam int NREGS = 9;
  localparam int SELW  = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [NBITS-1:0] c_bus;
  logic [NREGS-1:0] write_c;
  logic [SELW-1:0]  enable_a, enable_b;
  logic [NBITS-1:0] a_bus, b_bus;
  logic [2:0]       mem_control;
  logic             stall, mem_err;
  logic             dmem_req, dmem_we;
  logic [NBITS-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic             dmem_ack;
  logic             imem_req;
  logic [NBITS-1:0] imem_addr;
  logic [7:0]       imem_rdata;
  logic             imem_ack;

  logic [31:0] sb [$];
  logic [31:0] model [NREGS];
  logic [7:0]  mbr_m;
  logic [31:0] exp_v;
  int          checks = 0;
  int          errors = 0;
  int          stall_cnt;

  always #5 clk = ~clk;

  mic_register_file_hs #(.NBITS(NBITS), .NREGS(NREGS), .SELW(SELW)) dut (
    .clk(clk), .reset(reset), .c_bus(c_bus), .write_c(write_c),
    .enable_a(enable_a), .enable_b(enable_b), .a_bus(a_bus), .b_bus(b_bus),
    .mem_control(mem_control), .stall(stall), .mem_err(mem_err),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ack(imem_ack)
  );

  function automatic logic [31:0] exp_read(input int code);
    case (code)
      0: return model[7];
      1: return model[6];
      2: return {24'h0, mbr_m};
      3: return {{24{mbr_m[7]}}, mbr_m};
      4: return model[5];
      5: return model[4];
      6: return model[3];
      7: return model[2];
      8: return model[1];
      9: return model[0];
      default: return 32'h0;
    endcase
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NREGS; i++) model[i] = 32'h0;
    mbr_m = 8'h0;
  endtask

  task automatic write_reg(input int idx, input logic [31:0] val);
    write_c = '0;
    write_c[idx] = 1'b1;
    c_bus = val;
    @(negedge clk);
    write_c = '0;
    model[idx] = val;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    clear_model();
  endtask

  task automatic test_reset();
    reset = 1'b0; c_bus = 32'hFFFF_FFFF; write_c = '0; enable_a = '0; enable_b = '0;
    mem_control = 3'b000; dmem_rdata = '0; dmem_ack = 1'b0; imem_rdata = '0; imem_ack = 1'b0;
    repeat (2) @(negedge clk);
    clear_model();
    for (int code = 0; code < 16; code++) begin
      enable_a = 4'(code);
      enable_b = 4'(15 - code);
      sb.push_back(exp_read(code));
      sb.push_back(exp_read(15 - code));
      #1;
      exp_v = sb.pop_front(); checks++;
      if (a_bus !== exp_v) begin errors++; $display("FAIL reset_a code=%0d got=%h exp=%h", code, a_bus, exp_v); end
      exp_v = sb.pop_front(); checks++;
      if (b_bus !== exp_v) begin errors++; $display("FAIL reset_b code=%0d got=%h exp=%h", 15 - code, b_bus, exp_v); end
    end
    checks++;
    if ({stall, mem_err, dmem_req, dmem_we, imem_req} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got=%b exp=00000", {stall, mem_err, dmem_req, dmem_we, imem_req});
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_regwrite();
    write_reg(5, 32'hDEAD_BEEF);
    enable_b = 4'd4; enable_a = 4'd9;
    sb.push_back(32'hDEAD_BEEF); sb.push_back(32'h0);
    #1;
    exp_v = sb.pop_front(); checks++;
    if (b_bus !== exp_v) begin errors++; $display("FAIL sp_write_b got=%h exp=%h", b_bus, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (a_bus !== exp_v) begin errors++; $display("FAIL sp_write_a got=%h exp=%h", a_bus, exp_v); end
    @(negedge clk);
    for (int i = 0; i < NREGS; i++) write_reg(i, 32'hA500_0000 + 32'(i) * 32'h0101_0101);
    for (int code = 0; code < 16; code++) begin
      enable_a = 4'(code);
      enable_b = 4'(15 - code);
      sb.push_back(exp_read(code));
      sb.push_back(exp_read(15 - code));
      #1;
      exp_v = sb.pop_front(); checks++;
      if (a_bus !== exp_v) begin errors++; $display("FAIL map_a code=%0d got=%h exp=%h", code, a_bus, exp_v); end
      exp_v = sb.pop_front(); checks++;
      if (b_bus !== exp_v) begin errors++; $display("FAIL map_b code=%0d got=%h exp=%h", 15 - code, b_bus, exp_v); end
      @(negedge clk);
    end
  endtask

  task automatic test_data_read();
    write_reg(8, 32'd5);
    write_reg(7, 32'h0BAD_0BAD);
    mem_control = 3'b010;
    sb.push_back(32'h0000_1234);
    @(negedge clk);
    mem_control = 3'b000;
    write_c = '0; write_c[8] = 1'b1; c_bus = 32'd99;   // MAR rewrite while busy
    stall_cnt = 0;
    #1;
    if (stall) stall_cnt++;
    checks++;
    if ({dmem_req, dmem_we, dmem_addr} !== {1'b1, 1'b0, 32'd20}) begin
      errors++; $display("FAIL rd_issue req=%b we=%b addr=%0d exp req=1 we=0 addr=20", dmem_req, dmem_we, dmem_addr);
    end
    @(negedge clk);
    write_c = '0; model[8] = 32'd99;
    #1;
    if (stall) stall_cnt++;
    checks++;
    if (dmem_addr !== 32'd20) begin errors++; $display("FAIL rd_addr_hold got=%0d exp=20", dmem_addr); end
    @(negedge clk);
    #1;
    if (stall) stall_cnt++;
    @(negedge clk);
    dmem_ack = 1'b1; dmem_rdata = 32'h0000_1234;
    write_c = '0; write_c[7] = 1'b1; c_bus = 32'hFFFF_FFFF;   // loses to the read data
    #1;
    if (stall) stall_cnt++;
    @(negedge clk);
    dmem_ack = 1'b0; write_c = '0; enable_b = 4'd0;
    exp_v = sb.pop_front(); model[7] = exp_v;
    #1;
    checks++;
    if (b_bus !== exp_v) begin errors++; $display("FAIL rd_mdr got=%h exp=%h", b_bus, exp_v); end
    checks++;
    if (stall_cnt !== 4) begin errors++; $display("FAIL rd_stall_cycles got=%0d exp=4", stall_cnt); end
    checks++;
    if ({stall, dmem_req} !== 2'b00) begin errors++; $display("FAIL rd_done stall=%b req=%b exp 0 0", stall, dmem_req); end
    @(negedge clk);
  endtask

  task automatic test_data_write();
    write_reg(7, 32'hCAFE_F00D);
    write_reg(8, 32'd3);
    mem_control = 3'b100;
    @(negedge clk);
    mem_control = 3'b000;
    #1;
    checks++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata} !== {1'b1, 1'b1, 32'd12, 32'hCAFE_F00D}) begin
      errors++; $display("FAIL wr_issue req=%b we=%b addr=%0d wdata=%h exp 1 1 12 cafef00d", dmem_req, dmem_we, dmem_addr, dmem_wdata);
    end
    dmem_ack = 1'b1; dmem_rdata = 32'h5555_5555;
    @(negedge clk);
    dmem_ack = 1'b0; enable_b = 4'd0;
    sb.push_back(model[7]);
    #1;
    exp_v = sb.pop_front(); checks++;
    if (b_bus !== exp_v) begin errors++; $display("FAIL wr_mdr_kept got=%h exp=%h", b_bus, exp_v); end
    checks++;
    if ({stall, dmem_req, dmem_we} !== 3'b000) begin errors++; $display("FAIL wr_done got=%b exp=000", {stall, dmem_req, dmem_we}); end
    @(negedge clk);
  endtask

  task automatic test_fetch();
    write_reg(6, 32'd7);
    mem_control = 3'b001;
    @(negedge clk);
    mem_control = 3'b000;
    #1;
    checks++;
    if ({imem_req, stall, imem_addr} !== {1'b1, 1'b1, 32'd7}) begin
      errors++; $display("FAIL fetch_issue req=%b stall=%b addr=%0d exp 1 1 7", imem_req, stall, imem_addr);
    end
    imem_ack = 1'b1; imem_rdata = 8'h80;
    @(negedge clk);
    imem_ack = 1'b0; mbr_m = 8'h80;
`ifdef PC_AUTOINC_EN
    model[6] = model[6] + 32'd1;
`endif
    enable_a = 4'd3; enable_b = 4'd2;
    sb.push_back(32'hFFFF_FF80); sb.push_back(32'h0000_0080);
    #1;
    exp_v = sb.pop_front(); checks++;
    if (a_bus !== exp_v) begin errors++; $display("FAIL mbr_sext got=%h exp=%h", a_bus, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (b_bus !== exp_v) begin errors++; $display("FAIL mbr_zext got=%h exp=%h", b_bus, exp_v); end
    enable_a = 4'd1;
    sb.push_back(model[6]);
    #1;
    exp_v = sb.pop_front(); checks++;
    if (a_bus !== exp_v) begin errors++; $display("FAIL fetch_pc got=%0d exp=%0d", a_bus, exp_v); end
    // Ack while idle must change nothing.
    imem_ack = 1'b1; imem_rdata = 8'h11;
    @(negedge clk);
    imem_ack = 1'b0; enable_b = 4'd2;
    sb.push_back(32'h0000_0080); sb.push_back(model[6]);
    #1;
    exp_v = sb.pop_front(); checks++;
    if (b_bus !== exp_v) begin errors++; $display("FAIL idle_ack_mbr got=%h exp=%h", b_bus, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if ({imem_req, a_bus} !== {1'b0, exp_v}) begin errors++; $display("FAIL idle_ack_pc req=%b pc=%0d exp req=0 pc=%0d", imem_req, a_bus, exp_v); end
    @(negedge clk);
  endtask

  task automatic test_errors();
    do_reset();
    mem_control = 3'b110;
    @(negedge clk);
    mem_control = 3'b000;
    #1;
    checks++;
    if ({mem_err, dmem_req, stall} !== 3'b100) begin errors++; $display("FAIL rdwr_idle err/req/stall got=%b exp=100", {mem_err, dmem_req, stall}); end
    @(negedge clk);
    do_reset();
    #1;
    checks++;
    if (mem_err !== 1'b0) begin errors++; $display("FAIL err_cleared got=%b exp=0", mem_err); end
    write_reg(8, 32'd2);
    mem_control = 3'b010;
    @(negedge clk);
    mem_control = 3'b010;               // second rd while D_RD is busy
    @(negedge clk);
    mem_control = 3'b000;
    #1;
    checks++;
    if ({mem_err, dmem_req, stall, dmem_addr} !== {3'b111, 32'd8}) begin
      errors++; $display("FAIL busy_rd err=%b req=%b stall=%b addr=%0d exp 1 1 1 8", mem_err, dmem_req, stall, dmem_addr);
    end
    dmem_ack = 1'b1; dmem_rdata = 32'd77;
    @(negedge clk);
    dmem_ack = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({mem_err, dmem_req, stall} !== 3'b100) begin errors++; $display("FAIL busy_rd_after err/req/stall got=%b exp=100", {mem_err, dmem_req, stall}); end
    do_reset();
    mem_control = 3'b001;
    @(negedge clk);
    mem_control = 3'b001;               // second fetch while F_WAIT is busy
    @(negedge clk);
    mem_control = 3'b000;
    #1;
    checks++;
    if ({mem_err, imem_req} !== 2'b11) begin errors++; $display("FAIL busy_fetch err/req got=%b exp=11", {mem_err, imem_req}); end
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_abort(input logic [2:0] op);
    do_reset();
    write_reg(8, 32'd4);
    mem_control = op;
    @(negedge clk);
    mem_control = 3'b000;
    #1;
    checks++;
    if (dmem_req !== 1'b1) begin errors++; $display("FAIL abort_issue op=%b req=%b exp=1", op, dmem_req); end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1; clear_model();
    #1;
    checks++;
    if ({dmem_req, dmem_we, stall} !== 3'b000) begin errors++; $display("FAIL abort_reset op=%b got=%b exp=000", op, {dmem_req, dmem_we, stall}); end
    dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_0001;
    @(negedge clk);
    dmem_ack = 1'b0; enable_b = 4'd0;
    sb.push_back(model[7]);
    #1;
    exp_v = sb.pop_front(); checks++;
    if ({dmem_req, stall, b_bus} !== {2'b00, exp_v}) begin
      errors++; $display("FAIL abort_ack op=%b req=%b stall=%b mdr=%h exp 0 0 %h", op, dmem_req, stall, b_bus, exp_v);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    do_reset();
    write_reg(8, 32'd6);
    write_reg(6, 32'h20);
    mem_control = 3'b011;
    @(negedge clk);
    mem_control = 3'b000;
    #1;
    checks++;
    if ({dmem_req, imem_req, dmem_addr, imem_addr} !== {2'b11, 32'd24, 32'h20}) begin
      errors++; $display("FAIL concurrent_issue dreq=%b ireq=%b daddr=%0d iaddr=%h exp 1 1 24 20", dmem_req, imem_req, dmem_addr, imem_addr);
    end
    dmem_ack = 1'b1; dmem_rdata = 32'h7777_0001;
    imem_ack = 1'b1; imem_rdata = 8'h42;
    sb.push_back(32'h7777_0001); sb.push_back(32'h0000_0042);
    @(negedge clk);
    dmem_ack = 1'b0; imem_ack = 1'b0;
    model[7] = 32'h7777_0001; mbr_m = 8'h42;
    mem_control = 3'b010;               // new rd right after completion
    enable_a = 4'd0; enable_b = 4'd2;
    #1;
    exp_v = sb.pop_front(); checks++;
    if (a_bus !== exp_v) begin errors++; $display("FAIL concurrent_mdr got=%h exp=%h", a_bus, exp_v); end
    exp_v = sb.pop_front(); checks++;
    if (b_bus !== exp_v) begin errors++; $display("FAIL concurrent_mbr got=%h exp=%h", b_bus, exp_v); end
    @(negedge clk);
    mem_control = 3'b000;
    #1;
    checks++;
    if ({dmem_req, imem_req, stall, mem_err} !== 4'b1010) begin
      errors++; $display("FAIL b2b_issue dreq/ireq/stall/err got=%b exp=1010", {dmem_req, imem_req, stall, mem_err});
    end
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_regwrite();
    test_data_read();
    test_data_write();
    test_fetch();
    test_errors();
    test_reset_abort(3'b100);
    test_reset_abort(3'b010);
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
